// File: rtl/adder_64.sv
// ----------------------------------------------------------------------------
// adder_64
//
// 64-bit hierarchical carry-look-ahead adder with a single output register
// stage. Computes {cout, s} = a + b + cin combinationally through a three-level
// lookahead tree (4-bit groups -> 16-bit sections -> full word) and registers
// the result on the rising clock edge. Latency is one cycle, one add per cycle,
// with no handshake.
//
// Ports:
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous reset, active-high; clears all outputs at once
//   a     in   64  addend A (unsigned or two's complement)
//   b     in   64  addend B
//   cin   in   1   carry-in
//   s     out  64  registered sum, bits [63:0] of a+b+cin
//   cout  out  1   registered carry-out, bit 64 of a+b+cin
//   ovf   out  1   registered signed overflow (only when ADDER_OVF_EN is defined)
//
// Configuration macro:
//   ADDER_OVF_EN  when defined, adds the ovf port (c64 ^ c63), registered with
//                 the same latency and reset as s and cout.
// ----------------------------------------------------------------------------
module adder_64 (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] s,
`ifdef ADDER_OVF_EN
    output logic        cout,
    output logic        ovf
`else
    output logic        cout
`endif
);

    // Lookahead carries c1..c3 of a 4-wide block from its lower three
    // generate/propagate pairs and the block carry-in. Every carry is a flat
    // sum of products, so no carry depends on another carry in the same block.
    function automatic logic [2:0] carries3(input logic [2:0] g,
                                            input logic [2:0] p,
                                            input logic       c);
        logic [2:0] co;
        co[0] = g[0] | (p[0] & c);
        co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c);
        return co;
    endfunction

    // Block generate: G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
    function automatic logic gen4(input logic [3:0] g,
                                  input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [63:0] w_g;      // bit generate
    logic [63:0] w_p;      // bit propagate
    logic [64:0] w_c;      // carry into each bit; w_c[64] is the carry-out
    logic [15:0] w_grpG;   // 4-bit group generate
    logic [15:0] w_grpP;   // 4-bit group propagate
    logic [3:0]  w_secG;   // 16-bit section generate
    logic [3:0]  w_secP;   // 16-bit section propagate
    logic [3:0]  w_secC;   // carry into each section
    logic [63:0] w_sum;

    logic [63:0] r_s;
    logic        r_cout;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Level 1: sixteen 4-bit groups. Each consumes its group carry-in from
    // level 2 and produces the three carries internal to the group.
    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : gen_group
            assign w_grpG[k]          = gen4(w_g[4*k +: 4], w_p[4*k +: 4]);
            assign w_grpP[k]          = &w_p[4*k +: 4];
            assign w_c[4*k+1 +: 3]    = carries3(w_g[4*k +: 3], w_p[4*k +: 3],
                                                 w_c[4*k]);
        end
    endgenerate

    // Level 2: four section units over four groups each. They supply the
    // carries into groups 1..3 of their section and the section G/P.
    genvar j;
    generate
        for (j = 0; j < 4; j++) begin : gen_section
            assign w_secG[j] = gen4(w_grpG[4*j +: 4], w_grpP[4*j +: 4]);
            assign w_secP[j] = &w_grpP[4*j +: 4];
            assign {w_c[16*j+12], w_c[16*j+8], w_c[16*j+4]} =
                carries3(w_grpG[4*j +: 3], w_grpP[4*j +: 3], w_secC[j]);
            assign w_c[16*j] = w_secC[j];
        end
    endgenerate

    // Level 3: a single unit over the four sections yields c16, c32, c48 and
    // the final carry-out c64.
    assign w_secC[0]   = cin;
    assign w_secC[3:1] = carries3(w_secG[2:0], w_secP[2:0], cin);
    assign w_c[64]     = gen4(w_secG, w_secP) | ((&w_secP) & cin);

    assign w_sum = w_p ^ w_c[63:0];

    // Output register. Reset clears the result immediately and holds it at
    // zero; the first edge after release captures whatever is on the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c[64];
        end
    end

    assign s    = r_s;
    assign cout = r_cout;

`ifdef ADDER_OVF_EN
    logic r_ovf;

    // Two's-complement overflow occurs when the carries into and out of the
    // sign bit disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_c[64] ^ w_c[63];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_adder_64.sv
// ----------------------------------------------------------------------------
// tb_adder_64
//
// Self-checking bench for adder_64: directed vectors with hand-computed
// results, then random traffic checked every cycle against an arithmetic
// model, including a reset pulse in the middle of the stream. Signed overflow
// is checked only when ADDER_OVF_EN is defined.
// ----------------------------------------------------------------------------
module tb_adder_64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] a   = '0;
    logic [63:0] b   = '0;
    logic        cin = 1'b0;
    logic [63:0] s;
    logic        cout;
`ifdef ADDER_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    logic [64:0] mRes;
    logic        mOvf;

    logic [63:0] lastS;
    logic        lastC;
    logic        lastO;

    adder_64 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s),
`ifdef ADDER_OVF_EN
        .cout (cout),
        .ovf  (ovf)
`else
        .cout (cout)
`endif
    );

    always #5 clk = ~clk;

    // Signed overflow from the operand and result signs: same-sign operands
    // producing a result of the other sign.
    function automatic logic signedOvf(input logic [63:0] x,
                                       input logic [63:0] y,
                                       input logic        c);
        logic [63:0] t;
        t = x + y + {63'd0, c};
        return (x[63] == y[63]) && (t[63] != x[63]);
    endfunction

    // Reference model: the full 65-bit sum of the values on the inputs at each
    // edge, zeroed whenever reset is high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mRes <= '0;
            mOvf <= 1'b0;
        end else begin
            mRes <= {1'b0, a} + {1'b0, b} + {64'd0, cin};
            mOvf <= signedOvf(a, b, cin);
        end
    end

    // Every falling edge, once enabled, the registered outputs must match
    // the model.
    always @(negedge clk) begin
        if (checkEn) begin
            total++;
            if ({cout, s} !== mRes) begin
                bad++;
                $display("[TB] FAIL cycleCompare t=%0t: got cout=%b s=%h, want cout=%b s=%h",
                         $time, cout, s, mRes[64], mRes[63:0]);
            end
`ifdef ADDER_OVF_EN
            total++;
            if (ovf !== mOvf) begin
                bad++;
                $display("[TB] FAIL cycleOvf t=%0t: got ovf=%b, want ovf=%b",
                         $time, ovf, mOvf);
            end
`endif
        end
    end

    task automatic checkOutput(input string       name,
                               input logic [63:0] expS,
                               input logic        expC,
                               input logic        expO);
        total++;
        if (s !== expS || cout !== expC) begin
            bad++;
            $display("[TB] FAIL %s: got s=%h cout=%b, want s=%h cout=%b",
                     name, s, cout, expS, expC);
        end
`ifdef ADDER_OVF_EN
        total++;
        if (ovf !== expO) begin
            bad++;
            $display("[TB] FAIL %s_ovf: got ovf=%b, want ovf=%b", name, ovf, expO);
        end
`else
        if (expO === 1'bx) $display("[TB] note: unexpected x on expO in %s", name);
`endif
    endtask

    // Drive one vector away from the edge, confirm the output has not moved
    // before the next edge, then check the registered result after it.
    task automatic applyStimulus(input string       name,
                                 input logic [63:0] va,
                                 input logic [63:0] vb,
                                 input logic        vc,
                                 input logic [63:0] expS,
                                 input logic        expC,
                                 input logic        expO);
        @(posedge clk);
        #2;
        a   = va;
        b   = vb;
        cin = vc;
        #1;
        checkOutput({name, "_hold"}, lastS, lastC, lastO);
        @(posedge clk);
        #1;
        checkOutput(name, expS, expC, expO);
        lastS = expS;
        lastC = expC;
        lastO = expO;
    endtask

    initial begin
        // Reset with no clock edge yet: outputs must clear immediately.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncReset", 64'h0, 1'b0, 1'b0);
        checkEn = 1'b1;

        a   = 64'h0000ffff0000ffff;
        b   = 64'hffff0000ffff0000;
        cin = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("resetHold", 64'h0, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("firstEdge", 64'hffffffffffffffff, 1'b0, 1'b0);
        lastS = 64'hffffffffffffffff;
        lastC = 1'b0;
        lastO = 1'b0;

        applyStimulus("fullPropagate", 64'h0000ffff0000ffff, 64'hffff0000ffff0000, 1'b1,
                      64'h0000000000000000, 1'b1, 1'b0);
        applyStimulus("sparseBits", 64'h0001000000010000, 64'h0110000001100000, 1'b0,
                      64'h0111000001110000, 1'b0, 1'b0);
        applyStimulus("interleave", 64'h1100110011001100, 64'h0011001100110011, 1'b0,
                      64'h1111111111111111, 1'b0, 1'b0);
        applyStimulus("nibbles", 64'h0000101000001010, 64'h0000010100000101, 1'b0,
                      64'h0000111100001111, 1'b0, 1'b0);
        applyStimulus("wrapOnes", 64'hffffffffffffffff, 64'h1, 1'b0,
                      64'h0, 1'b1, 1'b0);
        applyStimulus("onesOnesCin", 64'hffffffffffffffff, 64'hffffffffffffffff, 1'b1,
                      64'hffffffffffffffff, 1'b1, 1'b0);
        applyStimulus("cinOnly", 64'h0, 64'h0, 1'b1,
                      64'h1, 1'b0, 1'b0);
        applyStimulus("signedOvf", 64'h7fffffffffffffff, 64'h1, 1'b0,
                      64'h8000000000000000, 1'b0, 1'b1);

        // Random traffic with a reset pulse in the middle.
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #2;
            if (i == 5000) begin
                rst = 1'b1;
                #1;
                checkOutput("midReset", 64'h0, 1'b0, 1'b0);
            end else if (i == 5003) begin
                rst = 1'b0;
            end
            a   = {$urandom, $urandom};
            b   = (i % 16 == 7) ? ~a : {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        checkEn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
